// File: rtl/spram64x32_ctrl_if.sv
// Request/response handshake bundle between a block-local master
// and the 64x32 single-port SRAM controller.
interface spram64x32_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/spram64x32_ctrl.sv
// Initiator-side controller for a 1-cycle-latency single-port SRAM:
// request stream to CEB/WEB strobes, read data returned via a credit FIFO.
module spram64x32_ctrl #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 32,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    spram64x32_ctrl_if.slave  bus,
    output logic              mem_ceb,
    output logic              mem_web,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy
);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic              init_done;
    logic              rd_inflight;
    logic              fire;
    logic              push;
    logic              pop;
    logic              rsp_valid;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [CNT_W:0]    used;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] fifo_mem [RSP_DEPTH];
    logic [ADDR_W-1:0] a_q;
    logic [DATA_W-1:0] d_q;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credits count both buffered data and the read whose data lands next cycle.
    assign used          = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, rd_inflight};
    assign bus.req_ready = init_done & (used < (CNT_W+1)'(RSP_DEPTH));
    assign fire          = bus.req_valid & bus.req_ready;

    assign mem_ceb = ~fire;
    assign mem_web = ~(fire & bus.req_we);
    assign mem_a   = fire ? bus.req_addr  : a_q;
    assign mem_d   = fire ? bus.req_wdata : d_q;

    assign push          = rd_inflight;
    assign rsp_valid     = (fifo_cnt != '0);
    assign pop           = rsp_valid & bus.rsp_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = fifo_mem[rd_ptr];
    assign busy          = rd_inflight | rsp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done   <= 1'b0;
            rd_inflight <= 1'b0;
            a_q         <= '0;
            d_q         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            init_done   <= 1'b1;
            rd_inflight <= fire & ~bus.req_we;
            if (fire) begin
                a_q <= bus.req_addr;
                d_q <= bus.req_wdata;
            end
            if (push) begin
                fifo_mem[wr_ptr] <= mem_q;
                wr_ptr           <= ptr_next(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_next(rd_ptr);
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_spram64x32_ctrl.sv
// Randomised bench for spram64x32_ctrl against a transaction-level
// model: outstanding-read queue, reference memory, credit limit.
module tb_spram64x32_ctrl;
    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] d;
        int          t;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_ceb, mem_web, busy;
    logic [5:0]  mem_a;
    logic [31:0] mem_d, mem_q;
    logic [31:0] sram [64];

    spram64x32_ctrl_if bus ();

    spram64x32_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .mem_ceb (mem_ceb),
        .mem_web (mem_web),
        .mem_a   (mem_a),
        .mem_d   (mem_d),
        .mem_q   (mem_q),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // SRAM macro behaviour: sequential write, read data one cycle later.
    always @(posedge clk) begin
        if (!mem_ceb) begin
            if (!mem_web) sram[mem_a] <= mem_d;
            else          mem_q <= sram[mem_a];
        end
    end

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          pops = 0;
    bit          init = 0;
    bit          fired;
    bit          obs_v;
    logic [31:0] obs_d;
    logic [5:0]  la;
    logic [31:0] ld;
    logic [31:0] ref_mem [64];
    ent_t        q[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: check DUT outputs against the model at the falling edge,
    // then advance the model by the transfers that happen at the rising edge.
    task automatic cycle();
        bit er, ev;
        @(negedge clk);
        if (!rst_n) begin
            q.delete();
            init = 0;
            la = '0;
            ld = '0;
        end
        er    = init && (q.size() < DEPTH);
        fired = bus.req_valid && er;
        ev    = (q.size() != 0) && (q[0].t <= cyc);
        chk("req_ready", bus.req_ready, er);
        chk("mem_ceb", mem_ceb, !fired);
        chk("mem_web", mem_web, !(fired && bus.req_we));
        chk("mem_a", mem_a, fired ? bus.req_addr : la);
        chk("mem_d", mem_d, fired ? bus.req_wdata : ld);
        chk("rsp_valid", bus.rsp_valid, ev);
        chk("busy", busy, q.size() != 0);
        if (ev) chk("rsp_rdata", bus.rsp_rdata, q[0].d);
        chk("no_overflow",
            (int'(dut.fifo_cnt) + int'(dut.rd_inflight)) <= DEPTH, 1);
        obs_v = bus.rsp_valid;
        obs_d = bus.rsp_rdata;
        if (ev && bus.rsp_ready) begin
            void'(q.pop_front());
            pops++;
        end
        if (fired) begin
            la = bus.req_addr;
            ld = bus.req_wdata;
            if (bus.req_we) ref_mem[bus.req_addr] = bus.req_wdata;
            else q.push_back('{d: ref_mem[bus.req_addr], t: cyc + 2});
        end
        if (rst_n) init = 1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_req(input bit we, input logic [5:0] a,
                          input logic [31:0] d);
        int n;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        n = 0;
        fired = 0;
        while (!fired && n < 20) begin
            cycle();
            n++;
        end
        chk("req_timeout", fired, 1);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            cycle();
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    initial begin
        int n, lat, p0, k;
        bit blocked;
        for (int i = 0; i < 64; i++) begin
            sram[i]    = '0;
            ref_mem[i] = '0;
        end
        mem_q         = '0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 6'h00;
        bus.req_wdata = 32'h1234_5678;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;

        // reset with a pending request, then first accept after init
        repeat (3) cycle();
        rst_n = 1'b1;
        n = 0;
        fired = 0;
        while (!fired && n < 10) begin
            cycle();
            n++;
        end
        chk("init_lat", n, 2);
        bus.req_valid = 1'b0;

        // write then read, latency 2
        do_req(1'b1, 6'h05, 32'hDEAD_BEEF);
        do_req(1'b0, 6'h05, 32'h0);
        lat = 0;
        obs_v = 0;
        while (!obs_v && lat < 10) begin
            cycle();
            lat++;
        end
        chk("rd_lat", lat, 2);
        chk("rd_data", obs_d, 32'hDEAD_BEEF);
        drain();

        // streaming fill and read-back
        for (int i = 0; i < 64; i++)
            do_req(1'b1, 6'(i), i * 32'h0101_0101);
        p0 = pops;
        for (int i = 0; i < 64; i++)
            do_req(1'b0, 6'(i), 32'h0);
        drain();
        chk("stream_cnt", pops - p0, 64);

        // backpressure: credits run out after two reads
        bus.rsp_ready = 1'b0;
        p0 = pops;
        do_req(1'b0, 6'h10, 32'h0);
        do_req(1'b0, 6'h11, 32'h0);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 6'h12;
        blocked = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (fired) blocked = 0;
        end
        chk("bp_block", blocked, 1);
        bus.rsp_ready = 1'b1;
        n = 0;
        fired = 0;
        while (!fired && n < 10) begin
            cycle();
            n++;
        end
        chk("bp_resume", fired, 1);
        bus.req_valid = 1'b0;
        drain();
        chk("bp_cnt", pops - p0, 3);

        // rsp_ready toggling during 20 random reads
        p0 = pops;
        k = 0;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 6'($urandom_range(63));
        while (k < 20 && n < 400) begin
            bus.rsp_ready = ~bus.rsp_ready;
            cycle();
            n++;
            if (fired) begin
                k++;
                bus.req_addr = 6'($urandom_range(63));
            end
        end
        chk("tog_issued", k, 20);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        drain();
        chk("tog_cnt", pops - p0, 20);

        // random mixed traffic
        for (int i = 0; i < 200; i++) begin
            bus.req_valid = 1'($urandom_range(1));
            bus.req_we    = 1'($urandom_range(1));
            bus.req_addr  = 6'($urandom_range(63));
            bus.req_wdata = $urandom;
            bus.rsp_ready = ($urandom_range(3) != 0);
            cycle();
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        drain();

        // reset right after a read fire discards it
        p0 = pops;
        do_req(1'b0, 6'h3F, 32'h0);
        rst_n = 1'b0;
        cycle();
        chk("rst_busy", busy, 0);
        cycle();
        rst_n = 1'b1;
        repeat (6) cycle();
        chk("rst_norsp", pops - p0, 0);
        do_req(1'b1, 6'h3F, 32'hCAFE_F00D);
        do_req(1'b0, 6'h3F, 32'h0);
        drain();
        chk("post_rst", pops - p0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
